// File: rtl/alu_core.sv
// Registered N-bit ALU: one operation per clock, result plus carry/borrow and zero flags.
// rst_n is active-high despite its name; it clears all outputs asynchronously.
module alu_core #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A_in,
  input  logic [N-1:0] B_in,
  input  logic [3:0]   alu_op,
  output logic [N-1:0] alu_out,
  output logic         carry_out,
  output logic         zero_flag
);

  typedef enum logic [3:0] {
    ALU_NOP = 4'h0,
    ALU_ADD = 4'h1,
    ALU_SUB = 4'h2,
    ALU_INC = 4'h3,
    ALU_DEC = 4'h4,
    ALU_AND = 4'h5,
    ALU_OR  = 4'h6,
    ALU_XOR = 4'h7
  } alu_op_e;

  localparam logic [N:0] ONE = {{N{1'b0}}, 1'b1};

  logic [N:0] a_ext;
  logic [N:0] b_ext;
  logic [N:0] result;
  logic       carry_next;

  assign a_ext = {1'b0, A_in};
  assign b_ext = {1'b0, B_in};

  // Bit N of the N+1-bit result is the carry for ADD/INC and the borrow for SUB/DEC.
  always_comb begin
    result     = a_ext;
    carry_next = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        result     = a_ext + b_ext;
        carry_next = result[N];
      end
      ALU_SUB: begin
        result     = a_ext - b_ext;
        carry_next = result[N];
      end
      ALU_INC: begin
        result     = a_ext + ONE;
        carry_next = result[N];
      end
      ALU_DEC: begin
        result     = a_ext - ONE;
        carry_next = result[N];
      end
      ALU_AND: result = a_ext & b_ext;
      ALU_OR:  result = a_ext | b_ext;
      ALU_XOR: result = a_ext ^ b_ext;
      default: result = a_ext;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      alu_out   <= '0;
      carry_out <= 1'b0;
      zero_flag <= 1'b0;
    end else begin
      alu_out   <= result[N-1:0];
      carry_out <= carry_next;
      zero_flag <= (result[N-1:0] == '0);
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Bench for alu_core: directed cases plus randomized operations checked against an integer reference model.
module tb_alu_core;

  logic       clk;
  logic       rst_n;
  logic [7:0] A_in;
  logic [7:0] B_in;
  logic [3:0] alu_op;
  logic [7:0] alu_out;
  logic       carry_out;
  logic       zero_flag;

  int checks = 0;
  int errors = 0;

  alu_core #(.N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A_in      (A_in),
    .B_in      (B_in),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .carry_out (carry_out),
    .zero_flag (zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the opcode rules. Returns {carry, zero, out}.
  function automatic logic [9:0] model(input int op, input int a, input int b);
    int r;
    logic c;
    c = 1'b0;
    case (op)
      1: begin r = a + b; c = (r > 255); end
      2: begin r = a - b; c = (a < b); end
      3: begin r = a + 1; c = (a == 255); end
      4: begin r = a - 1; c = (a == 0); end
      5: r = a & b;
      6: r = a | b;
      7: r = a ^ b;
      default: r = a;
    endcase
    if (r < 0) r = r + 256;
    r = r % 256;
    return {c, (r == 0), 8'(r)};
  endfunction

  task automatic check(input string tag, input logic [7:0] eo, input logic ec, input logic ez);
    checks++;
    assert (alu_out === eo) else begin
      errors++;
      $error("FAIL %s alu_out observed %h expected %h", tag, alu_out, eo);
    end
    checks++;
    assert (carry_out === ec) else begin
      errors++;
      $error("FAIL %s carry_out observed %b expected %b", tag, carry_out, ec);
    end
    checks++;
    assert (zero_flag === ez) else begin
      errors++;
      $error("FAIL %s zero_flag observed %b expected %b", tag, zero_flag, ez);
    end
  endtask

  task automatic step(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    alu_op = op;
    A_in   = a;
    B_in   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic step_model(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [9:0] e;
    e = model(int'(op), int'(a), int'(b));
    step(op, a, b);
    check(tag, e[7:0], e[9], e[8]);
  endtask

  initial begin
    logic [7:0] held_out;
    logic       held_c;
    logic       held_z;

    rst_n  = 1'b1;
    A_in   = 8'hFF;
    B_in   = 8'h01;
    alu_op = 4'h1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;

    step(4'h1, 8'h0A, 8'h05); check("add_0a_05", 8'h0F, 1'b0, 1'b0);
    step(4'h1, 8'hFF, 8'h01); check("add_ff_01", 8'h00, 1'b1, 1'b1);
    step(4'h2, 8'h0A, 8'h05); check("sub_0a_05", 8'h05, 1'b0, 1'b0);
    step(4'h2, 8'h05, 8'h0A); check("sub_05_0a", 8'hFB, 1'b1, 1'b0);
    step(4'h3, 8'hFF, 8'h00); check("inc_ff", 8'h00, 1'b1, 1'b1);
    step(4'h4, 8'h01, 8'h00); check("dec_01", 8'h00, 1'b0, 1'b1);
    step(4'h4, 8'h00, 8'h00); check("dec_00", 8'hFF, 1'b1, 1'b0);
    step(4'h5, 8'hAA, 8'h55); check("and_aa_55", 8'h00, 1'b0, 1'b1);
    step(4'h7, 8'hAA, 8'h55); check("xor_aa_55", 8'hFF, 1'b0, 1'b0);
    step(4'h6, 8'hAA, 8'h55); check("or_aa_55", 8'hFF, 1'b0, 1'b0);
    step(4'h0, 8'hFF, 8'h12); check("nop_ff", 8'hFF, 1'b0, 1'b0);
    step(4'hC, 8'h00, 8'h34); check("rsvd_c_00", 8'h00, 1'b0, 1'b1);
    step(4'hF, 8'h5A, 8'hFF); check("rsvd_f_5a", 8'h5A, 1'b0, 1'b0);
    step(4'h3, 8'h7F, 8'hFF); check("inc_7f_ignores_b", 8'h80, 1'b0, 1'b0);

    // Back-to-back: a new op every cycle, each result one edge later.
    step(4'h1, 8'h10, 8'h20); check("b2b_add", 8'h30, 1'b0, 1'b0);
    step(4'h2, 8'h10, 8'h20); check("b2b_sub", 8'hF0, 1'b1, 1'b0);
    step(4'h3, 8'h41, 8'h00); check("b2b_inc", 8'h42, 1'b0, 1'b0);
    step(4'h4, 8'h80, 8'h00); check("b2b_dec", 8'h7F, 1'b0, 1'b0);

    // Input changes between edges must not disturb the registered outputs.
    held_out = 8'h7F; held_c = 1'b0; held_z = 1'b0;
    #2; alu_op = 4'h1; A_in = 8'hFF; B_in = 8'hFF;
    #2; check("stable_mid1", held_out, held_c, held_z);
    alu_op = 4'h5; A_in = 8'h00; B_in = 8'h00;
    #2; check("stable_mid2", held_out, held_c, held_z);
    @(posedge clk); #1;
    check("after_toggle", 8'h00, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle after a nonzero result.
    step(4'h1, 8'h0A, 8'h05); check("pre_async", 8'h0F, 1'b0, 1'b0);
    #2; rst_n = 1'b1;
    #1; check("async_clear", 8'h00, 1'b0, 1'b0);
    alu_op = 4'h3; A_in = 8'hFF;
    @(posedge clk); #1;
    check("reset_held_edge", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
    step(4'h3, 8'hFF, 8'h00); check("release_first", 8'h00, 1'b1, 1'b1);

    for (int i = 0; i < 300; i++) begin
      step_model("rand", 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 16; i++) begin
      step_model("edge_ff", 4'(i), 8'hFF, 8'hFF);
      step_model("edge_00", 4'(i), 8'h00, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
